// File: rtl/tennis_pkg.sv
// Shared types and defaults for the LED tennis game blocks.
package tennis_pkg;

  localparam int DEF_WIN_POINTS = 7;
  localparam int DEF_SCORE_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RALLY = 2'd1,
    POINT = 2'd2,
    OVER  = 2'd3
  } state_t;

  // Player index, also used by the scoreboard display.
  typedef enum logic {
    PLAYER_ONE = 1'b0,
    PLAYER_TWO = 1'b1
  } player_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] value, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, value} + {7'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for a raw button plus a rising-edge press pulse.
module button_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic press
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= button;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  // Combinational so the referee registers the return on the third edge.
  assign press = sync2_reg & ~prev_reg;

endmodule

// File: rtl/rally_judge.sv
// Tennis referee: judges returns and misses, keeps score, rally length and game-over.
module rally_judge
  import tennis_pkg::*;
#(
  parameter int WIN_POINTS = DEF_WIN_POINTS,
  parameter int SCORE_W    = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               button_one,
  input  logic               button_two,
  input  logic               hittable_one,
  input  logic               hittable_two,
  input  logic               start_game,
  input  logic               clear_score,
  output logic               return_one,
  output logic               return_two,
  output logic               match_one,
  output logic               match_two,
  output logic [SCORE_W-1:0] score_one,
  output logic [SCORE_W-1:0] score_two,
  output logic [7:0]         rally_len,
  output logic               game_over,
  output logic               winner
);

  logic [1:0] buttons;
  logic [1:0] press;

  assign buttons = {button_two, button_one};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      button_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .button (buttons[gi]),
        .press  (press[gi])
      );
    end
  endgenerate

  state_t state_reg;
  logic   hit_prev_one_reg, hit_prev_two_reg;
  logic   latch_one_reg, latch_two_reg;

  logic               ret_one, ret_two;
  logic               close_one, close_two;
  logic               miss_one, miss_two;
  logic [SCORE_W-1:0] score_one_inc, score_two_inc;

  always_comb begin
    ret_one       = press[0] & hittable_one & ~latch_one_reg;
    ret_two       = press[1] & hittable_two & ~latch_two_reg;
    close_one     = hit_prev_one_reg & ~hittable_one;
    close_two     = hit_prev_two_reg & ~hittable_two;
    // Player one's miss wins if both windows close together.
    miss_one      = close_one & ~latch_one_reg;
    miss_two      = close_two & ~latch_two_reg & ~miss_one;
    score_one_inc = score_one + SCORE_W'(1);
    score_two_inc = score_two + SCORE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_prev_one_reg <= 1'b0;
      hit_prev_two_reg <= 1'b0;
    end else begin
      hit_prev_one_reg <= hittable_one;
      hit_prev_two_reg <= hittable_two;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      latch_one_reg <= 1'b0;
      latch_two_reg <= 1'b0;
      return_one    <= 1'b0;
      return_two    <= 1'b0;
      match_one     <= 1'b0;
      match_two     <= 1'b0;
      score_one     <= '0;
      score_two     <= '0;
      rally_len     <= 8'd0;
      game_over     <= 1'b0;
      winner        <= 1'b0;
    end else begin
      return_one <= 1'b0;
      return_two <= 1'b0;
      match_one  <= 1'b0;
      match_two  <= 1'b0;
      if (clear_score) begin
        state_reg     <= IDLE;
        latch_one_reg <= 1'b0;
        latch_two_reg <= 1'b0;
        score_one     <= '0;
        score_two     <= '0;
        rally_len     <= 8'd0;
        game_over     <= 1'b0;
        winner        <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start_game) begin
              state_reg     <= RALLY;
              rally_len     <= 8'd0;
              latch_one_reg <= 1'b0;
              latch_two_reg <= 1'b0;
            end
          end
          RALLY: begin
            return_one <= ret_one;
            return_two <= ret_two;
            rally_len  <= sat_add8(rally_len, {1'b0, ret_one} + {1'b0, ret_two});
            if (ret_one)        latch_one_reg <= 1'b1;
            else if (close_one) latch_one_reg <= 1'b0;
            if (ret_two)        latch_two_reg <= 1'b1;
            else if (close_two) latch_two_reg <= 1'b0;
            if (miss_one) begin
              match_two <= 1'b1;
              score_two <= score_two_inc;
              if (score_two_inc == SCORE_W'(WIN_POINTS)) begin
                state_reg <= OVER;
                game_over <= 1'b1;
                winner    <= PLAYER_TWO;
              end else begin
                state_reg <= POINT;
              end
            end else if (miss_two) begin
              match_one <= 1'b1;
              score_one <= score_one_inc;
              if (score_one_inc == SCORE_W'(WIN_POINTS)) begin
                state_reg <= OVER;
                game_over <= 1'b1;
                winner    <= PLAYER_ONE;
              end else begin
                state_reg <= POINT;
              end
            end
          end
          POINT: begin
            if (!start_game) state_reg <= IDLE;
          end
          OVER: begin
            game_over <= 1'b1;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rally_judge.sv
// Directed bench for rally_judge with WIN_POINTS = 3.
module tb_rally_judge;
  import tennis_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button_one = 1'b0, button_two = 1'b0;
  logic       hittable_one = 1'b0, hittable_two = 1'b0;
  logic       start_game = 1'b0, clear_score = 1'b0;
  logic       return_one, return_two, match_one, match_two;
  logic [3:0] score_one, score_two;
  logic [7:0] rally_len;
  logic       game_over, winner;

  int checks = 0;
  int passed = 0;

  rally_judge #(.WIN_POINTS(3), .SCORE_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button_one   (button_one),
    .button_two   (button_two),
    .hittable_one (hittable_one),
    .hittable_two (hittable_two),
    .start_game   (start_game),
    .clear_score  (clear_score),
    .return_one   (return_one),
    .return_two   (return_two),
    .match_one    (match_one),
    .match_two    (match_two),
    .score_one    (score_one),
    .score_two    (score_two),
    .rally_len    (rally_len),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ret1"}, 32'(return_one), 0);
    check({tag, "_ret2"}, 32'(return_two), 0);
    check({tag, "_m1"}, 32'(match_one), 0);
    check({tag, "_m2"}, 32'(match_two), 0);
    check({tag, "_s1"}, 32'(score_one), 0);
    check({tag, "_s2"}, 32'(score_two), 0);
    check({tag, "_rally"}, 32'(rally_len), 0);
    check({tag, "_over"}, 32'(game_over), 0);
    check({tag, "_win"}, 32'(winner), 0);
  endtask

  // who = 0: player one misses; who = 1: player two misses.
  task automatic miss_by(input logic who, input int exp_score, input logic exp_over);
    start_game = 1'b1;
    tick;
    if (who == 1'b0) hittable_one = 1'b1;
    else             hittable_two = 1'b1;
    tick;
    hittable_one = 1'b0;
    hittable_two = 1'b0;
    tick;
    if (who == 1'b0) begin
      check("miss_match_two", 32'(match_two), 1);
      check("miss_no_match_one", 32'(match_one), 0);
      check("miss_score_two", 32'(score_two), 32'(exp_score));
    end else begin
      check("miss_match_one", 32'(match_one), 1);
      check("miss_no_match_two", 32'(match_two), 0);
      check("miss_score_one", 32'(score_one), 32'(exp_score));
    end
    check("miss_game_over", 32'(game_over), 32'(exp_over));
    if (exp_over) check("miss_winner", 32'(winner), 32'(who == 1'b0 ? 1 : 0));
    $display("miss by player %0d: score %0d-%0d game_over %0d", who + 1, score_one, score_two, game_over);
    start_game = 1'b0;
    tick;
  endtask

  initial begin
    int ret_cnt;
    int ret_at;
    int match_cnt;

    // Reset with inputs toggling
    for (int i = 0; i < 4; i++) begin
      button_one   = i[0];
      button_two   = i[1];
      hittable_one = ~i[0];
      hittable_two = i[1];
      start_game   = 1'b1;
      tick;
      check_all_zero("in_reset");
    end
    button_one = 0; button_two = 0; hittable_one = 0; hittable_two = 0; start_game = 0;
    tick;
    rst_n = 1'b1;
    tick;
    check("rst_state", 32'(dut.state_reg), 32'(IDLE));
    check_all_zero("after_reset");
    $display("reset released");

    // Valid hit
    start_game = 1'b1;
    hittable_one = 1'b1;
    tick;
    check("hit_state", 32'(dut.state_reg), 32'(RALLY));
    button_one = 1'b1;
    ret_cnt = 0; ret_at = 0; match_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      tick;
      if (return_one) begin ret_cnt++; ret_at = i; end
      if (match_one || match_two) match_cnt++;
    end
    button_one = 1'b0;
    check("hit_ret_count", 32'(ret_cnt), 1);
    check("hit_ret_edge", 32'(ret_at), 3);
    check("hit_no_match", 32'(match_cnt), 0);
    check("hit_rally_len", 32'(rally_len), 1);
    $display("valid hit: returns %0d at edge %0d rally %0d", ret_cnt, ret_at, rally_len);

    // Window closes after a hit: no miss
    hittable_one = 1'b0;
    tick;
    check("close_hit_m2", 32'(match_two), 0);
    check("close_hit_state", 32'(dut.state_reg), 32'(RALLY));

    // Miss by player two
    hittable_two = 1'b1;
    tick;
    hittable_two = 1'b0;
    tick;
    check("miss2_match_one", 32'(match_one), 1);
    check("miss2_score_one", 32'(score_one), 1);
    check("miss2_state", 32'(dut.state_reg), 32'(POINT));
    tick;
    check("miss2_pulse_end", 32'(match_one), 0);
    start_game = 1'b0;
    tick;
    check("point_to_idle", 32'(dut.state_reg), 32'(IDLE));
    $display("miss by player 2: score %0d-%0d", score_one, score_two);

    // Out-of-window press
    start_game = 1'b1;
    tick;
    check("oow_rally_clr", 32'(rally_len), 0);
    ret_cnt = 0; match_cnt = 0;
    button_one = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) button_one = 1'b0;
      tick;
      if (return_one) ret_cnt++;
      if (match_one || match_two) match_cnt++;
    end
    check("oow_no_return", 32'(ret_cnt), 0);
    check("oow_no_match", 32'(match_cnt), 0);
    check("oow_score_one", 32'(score_one), 1);
    check("oow_score_two", 32'(score_two), 0);
    $display("out-of-window press: returns %0d", ret_cnt);

    // Repeat press inside an already-hit window
    hittable_one = 1'b1;
    tick;
    ret_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      button_one = (i < 4) || (i >= 7 && i < 11);
      tick;
      if (return_one) ret_cnt++;
    end
    button_one = 1'b0;
    check("repeat_ret_count", 32'(ret_cnt), 1);
    check("repeat_rally_len", 32'(rally_len), 1);
    hittable_one = 1'b0;
    tick;
    check("repeat_close_m2", 32'(match_two), 0);
    $display("repeat press: returns %0d", ret_cnt);

    // Race: press edge detected in the cycle the window falls
    hittable_one = 1'b1;
    tick;
    button_one = 1'b1;
    tick;
    tick;
    hittable_one = 1'b0;
    tick;
    check("race_match_two", 32'(match_two), 1);
    check("race_no_return", 32'(return_one), 0);
    check("race_score_two", 32'(score_two), 1);
    check("race_state", 32'(dut.state_reg), 32'(POINT));
    button_one = 1'b0;
    start_game = 1'b0;
    tick;
    $display("race: match_two %0d score %0d-%0d", match_two, score_one, score_two);

    // Game end
    clear_score = 1'b1;
    tick;
    clear_score = 1'b0;
    check("clr_score_one", 32'(score_one), 0);
    check("clr_score_two", 32'(score_two), 0);
    miss_by(1'b1, 1, 1'b0);
    miss_by(1'b1, 2, 1'b0);
    miss_by(1'b1, 3, 1'b1);
    check("over_state", 32'(dut.state_reg), 32'(OVER));
    hittable_two = 1'b1;
    tick;
    hittable_two = 1'b0;
    tick;
    check("over_no_m2", 32'(match_two), 0);
    check("over_no_m1", 32'(match_one), 0);
    check("over_score_hold", 32'(score_one), 3);
    check("over_hold", 32'(game_over), 1);
    clear_score = 1'b1;
    tick;
    clear_score = 1'b0;
    check("clr_state", 32'(dut.state_reg), 32'(IDLE));
    check_all_zero("clr");
    $display("game cleared: score %0d-%0d game_over %0d", score_one, score_two, game_over);

    // Async reset mid-rally
    miss_by(1'b0, 1, 1'b0);
    miss_by(1'b0, 2, 1'b0);
    start_game = 1'b1;
    tick;
    hittable_one = 1'b1;
    tick;
    hittable_one = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort_now");
    start_game = 1'b0;
    tick;
    check("abort_no_m2", 32'(match_two), 0);
    rst_n = 1'b1;
    tick;
    check("abort_state", 32'(dut.state_reg), 32'(IDLE));
    check("abort_score_two", 32'(score_two), 0);
    $display("reset mid-rally: score %0d-%0d", score_one, score_two);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rally_judge.md
# rally_judge

Referee for the LED tennis game. It consumes the ball block's `hittable_one`/`hittable_two`/`start_game` outputs and the players' raw buttons. It produces the `return_one`/`return_two` and `match_one`/`match_two` pulses that drive the ball block, and it keeps per-player score, rally length and game-over status for the display logic.

## Interface
- `WIN_POINTS`, 7: points needed to win a game; must be ≤ 2^SCORE_W − 1.
- `SCORE_W`, 4: width of each score register.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `button_one`, `button_two`  in  1  raw player buttons, asynchronous level.
- `hittable_one`, `hittable_two`  in  1  ball is in that player's hit window (from ball block).
- `start_game`  in  1  ball is in play (from ball block).
- `clear_score`  in  1  synchronous new-game request.
- `return_one`, `return_two`  out  1  one-cycle pulse: valid hit by that player.
- `match_one`, `match_two`  out  1  one-cycle pulse: point awarded to that player.
- `score_one`, `score_two`  out  SCORE_W  points won this game.
- `rally_len`  out  8  returns in the current rally, saturating at 255.
- `game_over`  out  1  a player has reached `WIN_POINTS`.
- `winner`  out  1  0 = player one, 1 = player two; valid only while `game_over`.

## Operation
- Each button passes through a 2-flop synchronizer, then a rising-edge detector, giving `press_x`.
- The hittable inputs are registered once (`hit_prev_x`) to detect their falling edges.
- State `IDLE`:
  - If `start_game` = 1: go to `RALLY`; clear `rally_len` and both hit latches.
  - Presses are ignored.
- State `RALLY`, for each player x:
  - If `press_x` & `hittable_x` & ~`latch_x`: pulse `return_x`, set `latch_x`, increment `rally_len` (saturating).
  - If `hit_prev_x` & ~`hittable_x` (window closed): if `latch_x` was set, clear it. Otherwise it is a miss: pulse the opponent's `match`, increment the opponent's score, and go to `POINT`, or to `OVER` if the new score equals `WIN_POINTS`.
  - Presses outside a window, and repeat presses inside an already-hit window, are ignored.
- State `POINT`: wait for `start_game` = 0, then go to `IDLE`.
- State `OVER`:
  - `game_over` = 1; `winner` holds.
  - No return or match pulses are generated.
- `clear_score` = 1 in any state has top priority: zero both scores, `rally_len`, `game_over` and the latches, and go to `IDLE` next cycle.
- If both windows close in the same cycle (illegal for the ball block), only player one's miss is judged; at most one `match` pulse fires per cycle.

## Timing
- Reset (`rst_n` low, asynchronous): all outputs 0, state `IDLE`, synchronizers and latches cleared. A reset mid-rally aborts the rally with no `match` pulse.
- `return_x` latency: high for exactly one cycle, after the 3rd rising edge at which the raw button is high (edge 1: sync1, edge 2: sync2, edge 3: output register).
- Race, press vs window close: a press is accepted only if `hittable_x` is still 1 in the cycle the edge is detected. If `hittable_x` falls in that same cycle, it is a miss.
- `match_x`: one cycle, registered, issued the cycle after `hittable` is sampled low. Scores update on the same edge as the `match` pulse.
- `game_over` and `winner` assert on the same edge as the winning `match` pulse.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `tennis_pkg`:
  - State enum (`IDLE`, `RALLY`, `POINT`, `OVER`).
  - Default `WIN_POINTS` and `SCORE_W` constants.
  - Player-index encoding (0 = one, 1 = two), shared with the scoreboard display.
- Sub-module `button_sync`: 2-flop synchronizer plus rising-edge pulse, with `clk`/`rst_n`. Instantiated once per button.

## Test plan
- Reset: drive `rst_n` = 0 with inputs toggling → all outputs 0. Release → state `IDLE`, `score_one` = `score_two` = 0.
- Valid hit:
  - Stimulus: `start_game` = 1, `hittable_one` = 1, `button_one` held high for 10 cycles.
  - Response: exactly one `return_one` pulse, after the 3rd edge; `rally_len` = 1; no `match`.
- Miss:
  - Stimulus: in `RALLY`, `hittable_two` goes 1→0 with no press.
  - Response: `match_one` for one cycle; `score_one` = 1; state `POINT`. Then `start_game` → 0 → state `IDLE`.
- Out-of-window press: `button_one` pulses with `hittable_one` = 0 → no `return_one`, no `match`, scores unchanged.
- Game end:
  - Stimulus: `WIN_POINTS` = 3; three misses by player two.
  - Response: `score_one` = 3, `game_over` = 1, `winner` = 0. A further `hittable_two` fall gives no `match_two`. `clear_score` → scores 0, `game_over` = 0, state `IDLE`.
- Race and abort:
  - Press edge detected in the same cycle `hittable_one` falls → `match_two`, no `return_one`.
  - Async reset mid-rally with `score_two` = 2 → immediate zero outputs, no pulse.
